// File: rtl/cgra_stream_pkg.sv
// rtl/cgra_stream_pkg.sv - shared types and constants for the CGRA stream engines
package cgra_stream_pkg;

  typedef logic [15:0] size_t;
  typedef logic [2:0]  state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_ABORT = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/cgra_stream_fifo.sv
// rtl/cgra_stream_fifo.sv - synchronous FIFO with registered storage, full/empty and flush
module cgra_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/cgra_output_writer.sv
// rtl/cgra_output_writer.sv - streams CGRA output results to consecutive words over AXI-Lite writes
module cgra_output_writer
  import cgra_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [15:0]           size_i,
  input  logic [31:0]           data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [31:0]           w_data_o,
  output logic [3:0]            w_strb_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  input  logic [1:0]            b_resp_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  stall_o
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  size_t                 size_q, size_d;
  logic [16:0]           acc_q, acc_d, iss_q, iss_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  act_q, act_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  done_q, done_d, err_q, err_d;

  logic        fifo_full, fifo_empty, fifo_push, fifo_flush;
  logic        can_start, active, aw_fin, w_fin, complete, b_hs;
  logic [31:0] fifo_head;

  cgra_stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (data_i),
    .pop_i   (complete),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // act_q keeps a presented AW/W pair alive until both halves handshake,
  // even if the state or outstanding count changes underneath it.
  assign can_start  = (state_q == ST_RUN) && !fifo_empty && (outst_q < OW'(MAX_OUTST));
  assign active     = act_q || can_start;
  assign aw_valid_o = active && !aw_done_q;
  assign w_valid_o  = active && !w_done_q;
  assign aw_fin     = aw_done_q || (aw_valid_o && aw_ready_i);
  assign w_fin      = w_done_q || (w_valid_o && w_ready_i);
  assign complete   = active && aw_fin && w_fin;
  assign b_hs       = b_valid_i && (outst_q != '0);

  assign data_ready_o = (state_q == ST_RUN) && !fifo_full && (acc_q < {1'b0, size_q});
  assign fifo_push    = data_ready_o && data_valid_i;
  assign stall_o      = data_valid_i && fifo_full;

  assign aw_addr_o = base_q + ADDR_WIDTH'({iss_q, 2'b00});
  assign w_data_o  = fifo_head;
  assign w_strb_o  = 4'hF;
  assign b_ready_o = 1'b1;
  assign busy_o    = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_ABORT);
  assign done_o    = done_q;
  assign error_o   = err_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    acc_d      = acc_q + {16'd0, fifo_push};
    iss_d      = iss_q + {16'd0, complete};
    done_d     = done_q;
    err_d      = err_q | (b_hs && (b_resp_i != RESP_OKAY));
    act_d      = active && !complete;
    aw_done_d  = active && !complete && aw_fin;
    w_done_d   = active && !complete && w_fin;
    fifo_flush = 1'b0;
    case ({complete, b_hs})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          base_d  = base_addr_i & ~ADDR_WIDTH'(3);
          size_d  = size_i;
          acc_d   = '0;
          iss_d   = '0;
          outst_d = '0;
          err_d   = 1'b0;
          done_d  = (size_i == '0);
          state_d = (size_i == '0) ? ST_DONE : ST_RUN;
        end else if (clear_i) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (clear_i) begin
          state_d = ST_ABORT;
        end else if (iss_d == {1'b0, size_q}) begin
          state_d = (outst_d == '0) ? ST_DONE : ST_DRAIN;
          done_d  = (outst_d == '0);
        end
      end
      ST_DRAIN: begin
        if (clear_i) begin
          state_d = ST_ABORT;
        end else if (outst_d == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_ABORT: begin
        done_d = 1'b0;
        if (!active) begin
          fifo_flush = 1'b1;
          if (outst_d == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      size_q    <= '0;
      acc_q     <= '0;
      iss_q     <= '0;
      outst_q   <= '0;
      act_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      size_q    <= size_d;
      acc_q     <= acc_d;
      iss_q     <= iss_d;
      outst_q   <= outst_d;
      act_q     <= act_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_cgra_output_writer.sv
// tb/tb_cgra_output_writer.sv - scoreboard bench for cgra_output_writer
module tb_cgra_output_writer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, clear_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] size_i = '0;
  logic [31:0] data_i = '0;
  logic        data_valid_i = 1'b0, data_ready_o;
  logic [31:0] aw_addr_o, w_data_o;
  logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
  logic [3:0]  w_strb_o;
  logic [1:0]  b_resp_i;
  logic        b_valid_i, b_ready_o;
  logic        busy_o, done_o, error_o, stall_o;

  cgra_output_writer #(.FIFO_DEPTH(4), .MAX_OUTST(4), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .base_addr_i(base_addr_i), .size_i(size_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int cyc = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, last_b_cyc = 0;
  int aw_hold = 0, w_hold = 0, err_at = -1;
  bit b_hold = 0;
  int max_outst = 0, max_ahead = 0;
  bit stall_seen = 0, stall_bad = 0;
  logic [63:0] expq [$];
  logic [31:0] awq [$];
  logic [31:0] wq [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // AXI-Lite slave: programmable ready stalls, B one cycle after each AW+W pair
  initial begin
    aw_ready_i = 1'b1; w_ready_i = 1'b1; b_valid_i = 1'b0; b_resp_i = 2'b00;
    forever begin
      @(posedge clk_i); #1;
      if (aw_hold > 0) begin aw_ready_i = 1'b0; aw_hold--; end else aw_ready_i = 1'b1;
      if (w_hold > 0) begin w_ready_i = 1'b0; w_hold--; end else w_ready_i = 1'b1;
      if (!b_hold && (min2(aw_cnt, w_cnt) - b_cnt) > 0) begin
        b_valid_i = 1'b1;
        b_resp_i  = (b_cnt == err_at) ? 2'b10 : 2'b00;
      end else begin
        b_valid_i = 1'b0;
        b_resp_i  = 2'b00;
      end
    end
  end

  // Monitor: pairs accepted AW addresses with W data and checks them against expectations
  initial begin
    logic [31:0] pa, pd, a, d;
    bit paw, pw;
    int o;
    paw = 0; pw = 0; pa = '0; pd = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (paw) chk("aw_stable", {31'd0, aw_valid_o, aw_addr_o}, {31'd0, 1'b1, pa});
        if (pw)  chk("w_stable", {31'd0, w_valid_o, w_data_o}, {31'd0, 1'b1, pd});
        if (aw_valid_o && aw_ready_i) begin awq.push_back(aw_addr_o); aw_cnt++; end
        if (w_valid_o && w_ready_i) begin wq.push_back(w_data_o); w_cnt++; end
        if (b_valid_i && b_ready_o) begin b_cnt++; last_b_cyc = cyc; end
        while (awq.size() > 0 && wq.size() > 0) begin
          a = awq.pop_front();
          d = wq.pop_front();
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=%0h/%0h expected=none", a, d);
          end else begin
            chk("write", {a, d}, expq.pop_front());
          end
        end
        o = min2(aw_cnt, w_cnt) - b_cnt;
        if (o > max_outst) max_outst = o;
        if (aw_cnt - w_cnt > max_ahead) max_ahead = aw_cnt - w_cnt;
        if (stall_o) stall_seen = 1;
        if (stall_o && (!data_valid_i || data_ready_o)) stall_bad = 1;
        paw = aw_valid_o && !aw_ready_i; pa = aw_addr_o;
        pw  = w_valid_o && !w_ready_i;   pd = w_data_o;
      end
    end
  end

  task automatic do_start(input logic [31:0] base, input logic [15:0] size);
    @(posedge clk_i); #1;
    base_addr_i = base; size_i = size; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("busy_after_start", {63'd0, busy_o}, {63'd0, size != 16'd0});
    chk("done_after_start", {63'd0, done_o}, {63'd0, size == 16'd0});
  endtask

  task automatic send_words(input logic [31:0] base, input int n, input logic [31:0] d0);
    int t;
    for (int i = 0; i < n; i++) begin
      expq.push_back({base + 32'(4 * i), d0 + 32'(i)});
      @(posedge clk_i); #1;
      data_i = d0 + 32'(i); data_valid_i = 1'b1;
      t = 0;
      @(negedge clk_i);
      while (!data_ready_o && t < 200) begin @(negedge clk_i); t++; end
      if (t >= 200) begin
        checks++; errors++;
        $display("FAIL data_accept_timeout actual=blocked expected=accepted");
      end
    end
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    @(negedge clk_i);
    while (!done_o && t < 500) begin @(negedge clk_i); t++; end
    chk({name, "_done"}, {63'd0, done_o}, 64'd1);
    chk({name, "_done_lat"}, 64'(cyc - last_b_cyc), 64'd1);
  endtask

  initial begin
    int aw0, b0, t;
    repeat (3) @(negedge clk_i);
    chk("rst_outs", {56'd0, data_ready_o, aw_valid_o, w_valid_o, busy_o, done_o, error_o, stall_o, b_ready_o},
        64'h01);
    chk("rst_strb_addr", {28'd0, w_strb_o, aw_addr_o}, {28'd0, 4'hF, 32'd0});
    chk("rst_wdata", {32'd0, w_data_o}, 64'd0);
    @(posedge clk_i); #1; rst_i = 1'b0;

    // basic transfer
    do_start(32'h9000_0050, 16'd4);
    send_words(32'h9000_0050, 4, 32'd1);
    wait_done("basic");
    chk("basic_err", {63'd0, error_o}, 64'd0);

    // backpressure with B responses held to fill the outstanding window
    max_outst = 0; stall_seen = 0; stall_bad = 0;
    do_start(32'h0000_1000, 16'd8);
    aw_hold = 10; w_hold = 3; b_hold = 1;
    fork
      send_words(32'h0000_1000, 8, 32'hA0);
      begin repeat (40) @(posedge clk_i); #1; b_hold = 0; end
    join
    wait_done("bp");
    chk("bp_max_outst", 64'(max_outst), 64'd4);
    chk("bp_stall_seen", {63'd0, stall_seen}, 64'd1);
    chk("bp_stall_bad", {63'd0, stall_bad}, 64'd0);

    // split handshakes: AW accepted ahead of W
    max_ahead = 0; aw0 = aw_cnt;
    do_start(32'h0000_2000, 16'd2);
    w_hold = 5;
    send_words(32'h0000_2000, 2, 32'h55);
    wait_done("split");
    chk("split_ahead", 64'(max_ahead), 64'd1);
    chk("split_count", 64'(aw_cnt - aw0), 64'd2);

    // size zero: done next cycle with no AXI traffic
    aw0 = aw_cnt;
    do_start(32'h0000_3000, 16'd0);
    repeat (4) @(negedge clk_i);
    chk("zero_no_aw", 64'(aw_cnt - aw0), 64'd0);
    chk("zero_done_hold", {63'd0, done_o}, 64'd1);

    // address wrap
    do_start(32'hFFFF_FFF8, 16'd3);
    send_words(32'hFFFF_FFF8, 3, 32'h11);
    wait_done("wrap");

    // SLVERR on the second B
    err_at = b_cnt + 1;
    do_start(32'h0000_4000, 16'd4);
    send_words(32'h0000_4000, 4, 32'h40);
    wait_done("err");
    chk("err_sticky", {63'd0, error_o}, 64'd1);
    err_at = -1;
    @(posedge clk_i); #1; clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
    @(negedge clk_i);
    chk("clear_in_done", {62'd0, done_o, error_o}, 64'd0);

    // abort with two B responses pending
    b_hold = 1; aw0 = aw_cnt; b0 = b_cnt;
    do_start(32'h0000_5000, 16'd8);
    send_words(32'h0000_5000, 2, 32'h70);
    t = 0;
    while (min2(aw_cnt, w_cnt) - aw0 < 2 && t < 200) begin @(negedge clk_i); t++; end
    chk("abort_issued", 64'(min2(aw_cnt, w_cnt) - aw0), 64'd2);
    @(posedge clk_i); #1; clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("abort_busy_wait", {63'd0, busy_o}, 64'd1);
    @(posedge clk_i); #1; b_hold = 0;
    t = 0;
    @(negedge clk_i);
    while (busy_o && t < 200) begin @(negedge clk_i); t++; end
    chk("abort_idle", {62'd0, busy_o, done_o}, 64'd0);
    chk("abort_aw", 64'(aw_cnt - aw0), 64'd2);
    chk("abort_b", 64'(b_cnt - b0), 64'd2);

    do_start(32'h0000_6000, 16'd2);
    send_words(32'h0000_6000, 2, 32'h77);
    wait_done("restart");
    chk("restart_err", {63'd0, error_o}, 64'd0);

    repeat (3) @(negedge clk_i);
    chk("exp_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
